oneshot_cmd_arbiter: RTL and testbench
======================================

# oneshot_cmd_arbiter

Round-robin scheduler for a bank of one-shot command register bits. Each bit is a pending command, such as a rail power-up or power-down request. The block grants one pending bit at a time to the shared sequencer engine with a valid/ready handshake. It waits for the engine's completion, then pulses the matching acknowledge back to the one-shot register to clear the bit. It sits between the CSR one-shot register and the power sequencer core.

## Interface
- P_WIDTH, 4: number of one-shot command bits / requesters (1..32).
- P_TIMEOUT, 1000: watchdog limit in CLOCK cycles (only used with timeout feature).
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- REQ_IN  in  P_WIDTH  one-shot register outputs; bit i high = command i pending.
- CMD_VALID  out  1  command offered to sequencer.
- CMD_IDX  out  IW = max(1,$clog2(P_WIDTH))  index of granted command.
- CMD_READY  in  1  sequencer accepts command.
- CMD_DONE  in  1  sequencer finished the accepted command (single-cycle pulse).
- ACK_OUT  out  P_WIDTH  one-hot, one-cycle clear pulse to the one-shot register.
- BUSY  out  1  high whenever state is not IDLE.
- TIMEOUT_ERR  out  1  sticky watchdog error flag.
- ERR_CLR  in  1  clears TIMEOUT_ERR.

## Operation
- States: IDLE, OFFER, EXEC, ACK.
- IDLE: if REQ_IN != 0, select the first set bit searching upward from LAST+1, with modulo P_WIDTH wrap. Register it into CMD_IDX and go to OFFER.
- OFFER: CMD_VALID = 1, with CMD_IDX held stable. On CMD_READY = 1, go to EXEC and set LAST = CMD_IDX.
- EXEC: CMD_VALID = 0. On CMD_DONE = 1, go to ACK.
- ACK: ACK_OUT[CMD_IDX] = 1 for exactly one cycle, then go to IDLE.
  - The one-shot register clears the bit on that same edge, so the bit is low when IDLE samples again.
- CMD_DONE is ignored outside EXEC. CMD_READY is ignored outside OFFER.
- A request that drops while in OFFER (e.g. software rewrites 0) does not cancel the command. The command completes and is acknowledged normally.
- Reset values:
  - State IDLE.
  - CMD_VALID = 0, CMD_IDX = 0, ACK_OUT = 0, BUSY = 0, TIMEOUT_ERR = 0.
  - LAST = P_WIDTH-1, so bit 0 wins first.
- Reset asserted mid-operation immediately forces all of the above reset values. No ACK is issued, so the pending bit stays set in the one-shot register and is re-arbitrated after reset.
- All outputs are registered, with no combinational input-to-output paths.

## Timing
- REQ_IN nonzero sampled at edge N: CMD_VALID high from N+1.
- CMD_READY high in the same cycle as CMD_VALID: handshake completes at that edge, and CMD_VALID is low the following cycle.
- CMD_DONE sampled at edge M: ACK_OUT pulse during cycle M+1, and IDLE from M+2.
- Minimum command turnaround, with READY tied high and DONE one cycle after accept: 4 cycles. A back-to-back pending request is offered again 1 cycle after the ACK cycle.
- Fairness: with all bits continuously pending, grants rotate 0,1,2,…,P_WIDTH-1,0.

## Configuration
- `ONESHOT_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(P_TIMEOUT+1) runs while in OFFER or EXEC and is cleared on entry to OFFER.
  - When the count reaches P_TIMEOUT, go to ACK: drop CMD_VALID, acknowledge the bit anyway, and set TIMEOUT_ERR.
  - TIMEOUT_ERR clears on ERR_CLR. If set and ERR_CLR occur in the same cycle, set wins.
- `ONESHOT_ARB_TIMEOUT_EN` not defined:
  - No counter is built, and the block waits indefinitely in OFFER and EXEC.
  - TIMEOUT_ERR is tied to 0, and ERR_CLR is ignored.

## Test plan
- Reset, then REQ_IN=4'b0100, READY=1, DONE two cycles after accept. Required: CMD_IDX=2, one CMD_VALID cycle, ACK_OUT=4'b0100 for one cycle, BUSY low again after ACK.
- REQ_IN=4'b1111 held, with the model clearing bits on ACK. Required: grant order 0,1,2,3, each ACK one-hot, no bit granted twice.
- CMD_READY held low for 10 cycles in OFFER. Required: CMD_VALID and CMD_IDX stable throughout; accept on the first READY edge.
- Spurious CMD_DONE in IDLE and in OFFER. Required: no state change and no ACK.
- Assert RESET_N low while in EXEC with REQ_IN=4'b0010. Required: all outputs 0 immediately, no ACK; after release, bit 1 is offered again.
- With `ONESHOT_ARB_TIMEOUT_EN` and P_TIMEOUT=16, DONE never arrives. Required: ACK pulse for the granted bit 16 cycles after OFFER entry, TIMEOUT_ERR=1 until ERR_CLR; ERR_CLR in the same cycle as a new timeout leaves TIMEOUT_ERR=1.

Source files
------------

// File: rtl/oneshot_cmd_arbiter.sv
// Round-robin scheduler that hands pending one-shot command bits to a shared sequencer, one at a time.
// Optional watchdog is built when ONESHOT_ARB_TIMEOUT_EN is defined.
module oneshot_cmd_arbiter #(
  parameter int P_WIDTH   = 4,
  parameter int P_TIMEOUT = 1000,
  localparam int IW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic [P_WIDTH-1:0] REQ_IN,
  output logic               CMD_VALID,
  output logic [IW-1:0]      CMD_IDX,
  input  logic               CMD_READY,
  input  logic               CMD_DONE,
  output logic [P_WIDTH-1:0] ACK_OUT,
  output logic               BUSY,
  output logic               TIMEOUT_ERR,
  input  logic               ERR_CLR
);

  typedef enum logic [1:0] {IDLE, OFFER, EXEC, ACK} state_t;

  state_t             state;
  state_t             state_next;
  logic [IW-1:0]      last_idx;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic [P_WIDTH-1:0] hi_mask;
  logic [P_WIDTH-1:0] hi_req;
  logic [P_WIDTH-1:0] pick_vec;
  logic               timeout_hit;

  // Prefer requests above the last grant; fall back to the lowest request to wrap around.
  always_comb begin
    hi_mask    = ~((P_WIDTH'(2) << last_idx) - P_WIDTH'(1));
    hi_req     = REQ_IN & hi_mask;
    pick_vec   = (hi_req != '0) ? hi_req : REQ_IN;
    pick_found = (REQ_IN != '0);
    pick_idx   = '0;
    for (int j = P_WIDTH - 1; j >= 0; j--) begin
      if (pick_vec[j]) pick_idx = IW'(j);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = OFFER;
      OFFER:   if (CMD_READY) state_next = EXEC;
      EXEC:    if (CMD_DONE) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = ACK;
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      CMD_IDX   <= '0;
      last_idx  <= IW'(P_WIDTH - 1);
      CMD_VALID <= 1'b0;
      ACK_OUT   <= '0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_next;
      CMD_VALID <= (state_next == OFFER);
      BUSY      <= (state_next != IDLE);
      ACK_OUT   <= (state_next == ACK) ? (P_WIDTH'(1) << CMD_IDX) : '0;
      if (state == IDLE && pick_found) CMD_IDX <= pick_idx;
      if (state == OFFER && state_next == EXEC) last_idx <= CMD_IDX;
    end
  end

`ifdef ONESHOT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(P_TIMEOUT + 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;

  assign timeout_hit = ((state == OFFER) || (state == EXEC)) && (to_cnt == CW'(P_TIMEOUT - 1));
  assign TIMEOUT_ERR = err_q;

  // Counter sits at zero in IDLE, so it is clear on every entry to OFFER; a new timeout beats ERR_CLR.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == OFFER || state == EXEC) to_cnt <= to_cnt + 1'b1;
      else                                 to_cnt <= '0;
      if (timeout_hit)  err_q <= 1'b1;
      else if (ERR_CLR) err_q <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign TIMEOUT_ERR        = 1'b0;
  assign unused_timeout_cfg = ERR_CLR | (P_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_oneshot_cmd_arbiter.sv
// Self-checking bench for oneshot_cmd_arbiter: directed scenarios plus randomized traffic against a round-robin model.
// The bench emulates the one-shot register: pending bits clear when ACK_OUT pulses.
module tb_oneshot_cmd_arbiter;

  logic       CLOCK;
  logic       RESET_N;
  logic [3:0] pending;
  logic       CMD_VALID;
  logic [1:0] CMD_IDX;
  logic       CMD_READY;
  logic       CMD_DONE;
  logic [3:0] ACK_OUT;
  logic       BUSY;
  logic       TIMEOUT_ERR;
  logic       ERR_CLR;

  int n_checks = 0;
  int n_fail   = 0;
  int last_model;

  oneshot_cmd_arbiter #(.P_WIDTH(4), .P_TIMEOUT(16)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .REQ_IN(pending),
    .CMD_VALID(CMD_VALID), .CMD_IDX(CMD_IDX), .CMD_READY(CMD_READY),
    .CMD_DONE(CMD_DONE), .ACK_OUT(ACK_OUT), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Next grant: first pending bit strictly after the last grant, wrapping modulo 4.
  function automatic int rr_pick(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge CLOCK);
    if (ACK_OUT != 4'b0) pending = pending & ~ACK_OUT;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && CMD_VALID !== 1'b1; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET_N = 1'b0; CMD_READY = 1'b0; CMD_DONE = 1'b0; ERR_CLR = 1'b0; pending = 4'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    last_model = 3;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; CMD_READY = 1'b0; CMD_DONE = 1'b0; ERR_CLR = 1'b0; pending = 4'b0;
    tick(); tick();
    n_checks++;
    if ({CMD_VALID, CMD_IDX, ACK_OUT, BUSY, TIMEOUT_ERR} !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%b idx=%0d ack=%b busy=%b err=%b, expected all 0",
               CMD_VALID, CMD_IDX, ACK_OUT, BUSY, TIMEOUT_ERR);
    end
    RESET_N = 1'b1;
    tick();
    n_checks++;
    if ({CMD_VALID, BUSY} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle: got v=%b busy=%b expected 0 0", CMD_VALID, BUSY);
    end
    last_model = 3;
  endtask

  task automatic test_single();
    do_reset();
    pending = 4'b0100; CMD_READY = 1'b1;
    tick();
    n_checks++;
    if ({CMD_VALID, CMD_IDX, BUSY} !== {1'b1, 2'd2, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL single_offer: got v=%b idx=%0d busy=%b expected 1 2 1", CMD_VALID, CMD_IDX, BUSY);
    end
    tick();
    CMD_READY = 1'b0;
    n_checks++;
    if ({CMD_VALID, BUSY} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL single_one_valid: got v=%b busy=%b expected 0 1", CMD_VALID, BUSY);
    end
    tick();
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    n_checks++;
    if ({ACK_OUT, BUSY} !== {4'b0100, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL single_ack: got ack=%b busy=%b expected 0100 1", ACK_OUT, BUSY);
    end
    tick();
    n_checks++;
    if ({ACK_OUT, BUSY, CMD_VALID} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL single_after_ack: got ack=%b busy=%b v=%b expected 0000 0 0", ACK_OUT, BUSY, CMD_VALID);
    end
    last_model = 2;
  endtask

  task automatic test_fairness();
    int grants = 0;
    int prev = -1;
    int exp;
    logic [3:0] seen = 4'b0;
    logic [3:0] exp_ack;
    do_reset();
    pending = 4'b1111; CMD_READY = 1'b1; CMD_DONE = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (CMD_VALID === 1'b1) begin
        exp = rr_pick(pending, last_model);
        n_checks++;
        if (CMD_IDX !== 2'(exp)) begin
          n_fail++;
          $display("[TB] FAIL fair_order: got idx=%0d expected %0d", CMD_IDX, exp);
        end
        n_checks++;
        if (seen[CMD_IDX] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL fair_repeat: bit %0d granted twice, seen=%b expected unseen", CMD_IDX, seen);
        end
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev != 4) begin
            n_fail++;
            $display("[TB] FAIL fair_turnaround: got %0d cycles expected 4", cyc - prev);
          end
        end
        prev = cyc;
        seen[CMD_IDX] = 1'b1;
        last_model = exp;
        grants++;
      end
      if (ACK_OUT !== 4'b0) begin
        exp_ack = 4'b0001 << last_model;
        n_checks++;
        if (ACK_OUT !== exp_ack) begin
          n_fail++;
          $display("[TB] FAIL fair_ack: got %b expected %b", ACK_OUT, exp_ack);
        end
      end
    end
    CMD_READY = 1'b0; CMD_DONE = 1'b0;
    n_checks++;
    if (grants != 4 || seen !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL fair_count: got %0d grants seen=%b expected 4 1111", grants, seen);
    end
  endtask

  task automatic test_ready_stall();
    int exp;
    pending = 4'b0010; CMD_READY = 1'b0;
    exp = rr_pick(pending, last_model);
    wait_valid(10);
    n_checks++;
    if (CMD_VALID !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_offer: got v=%b expected 1", CMD_VALID);
    end
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) pending = 4'b0000;
      tick();
      n_checks++;
      if ({CMD_VALID, CMD_IDX} !== {1'b1, 2'(exp)}) begin
        n_fail++;
        $display("[TB] FAIL stall_hold: cycle %0d got v=%b idx=%0d expected 1 %0d", i, CMD_VALID, CMD_IDX, exp);
      end
    end
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
    n_checks++;
    if ({CMD_VALID, BUSY} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL stall_accept: got v=%b busy=%b expected 0 1", CMD_VALID, BUSY);
    end
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    n_checks++;
    if (ACK_OUT !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL stall_dropped_ack: got %b expected 0010", ACK_OUT);
    end
    tick();
    n_checks++;
    if ({BUSY, CMD_VALID} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL stall_idle: got busy=%b v=%b expected 0 0", BUSY, CMD_VALID);
    end
    last_model = exp;
  endtask

  task automatic test_spurious_done();
    int exp;
    pending = 4'b0000; CMD_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({BUSY, ACK_OUT} !== 5'b0) begin
        n_fail++;
        $display("[TB] FAIL spur_idle: got busy=%b ack=%b expected 0 0000", BUSY, ACK_OUT);
      end
    end
    CMD_DONE = 1'b0;
    pending = 4'b1000;
    exp = rr_pick(pending, last_model);
    wait_valid(10);
    CMD_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({CMD_VALID, CMD_IDX, ACK_OUT} !== {1'b1, 2'(exp), 4'b0}) begin
        n_fail++;
        $display("[TB] FAIL spur_offer: got v=%b idx=%0d ack=%b expected 1 %0d 0000", CMD_VALID, CMD_IDX, ACK_OUT, exp);
      end
    end
    CMD_DONE = 1'b0; CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({BUSY, CMD_VALID, ACK_OUT} !== {1'b1, 1'b0, 4'b0}) begin
        n_fail++;
        $display("[TB] FAIL spur_exec_wait: got busy=%b v=%b ack=%b expected 1 0 0000", BUSY, CMD_VALID, ACK_OUT);
      end
    end
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    n_checks++;
    if (ACK_OUT !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL spur_ack: got %b expected 1000", ACK_OUT);
    end
    tick();
    last_model = exp;
  endtask

  task automatic test_reset_in_exec();
    int exp;
    pending = 4'b0010; CMD_READY = 1'b1;
    wait_valid(10);
    tick();
    CMD_READY = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({CMD_VALID, CMD_IDX, ACK_OUT, BUSY, TIMEOUT_ERR} !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL exec_reset_async: got v=%b idx=%0d ack=%b busy=%b err=%b expected all 0",
               CMD_VALID, CMD_IDX, ACK_OUT, BUSY, TIMEOUT_ERR);
    end
    tick();
    n_checks++;
    if (ACK_OUT !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL exec_reset_noack: got %b expected 0000", ACK_OUT);
    end
    tick();
    RESET_N = 1'b1;
    last_model = 3;
    exp = rr_pick(pending, last_model);
    wait_valid(10);
    n_checks++;
    if ({CMD_VALID, CMD_IDX} !== {1'b1, 2'(exp)}) begin
      n_fail++;
      $display("[TB] FAIL exec_reset_reoffer: got v=%b idx=%0d expected 1 %0d", CMD_VALID, CMD_IDX, exp);
    end
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0; CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    n_checks++;
    if (ACK_OUT !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL exec_reset_ack: got %b expected 0010", ACK_OUT);
    end
    tick();
    last_model = exp;
  endtask

  task automatic test_random();
    int exp;
    int dly;
    logic [3:0] exp_ack;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      if (pending == 4'b0) pending = 4'($urandom_range(1, 15));
      exp = rr_pick(pending, last_model);
      wait_valid(10);
      n_checks++;
      if ({CMD_VALID, CMD_IDX} !== {1'b1, 2'(exp)}) begin
        n_fail++;
        $display("[TB] FAIL rand_grant: iter %0d got v=%b idx=%0d expected 1 %0d", it, CMD_VALID, CMD_IDX, exp);
      end
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) tick();
      CMD_READY = 1'b1;
      tick();
      CMD_READY = 1'b0;
      last_model = exp;
      pending = pending | 4'($urandom_range(0, 15));
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) tick();
      CMD_DONE = 1'b1;
      tick();
      CMD_DONE = 1'b0;
      exp_ack = 4'b0001 << exp;
      n_checks++;
      if ({ACK_OUT, CMD_VALID} !== {exp_ack, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL rand_ack: iter %0d got ack=%b v=%b expected %b 0", it, ACK_OUT, CMD_VALID, exp_ack);
      end
      tick();
      n_checks++;
      if (BUSY !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rand_idle: iter %0d got busy=%b expected 0", it, BUSY);
      end
    end
  endtask

`ifdef ONESHOT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    pending = 4'b0001;
    wait_valid(10);
    for (int c = 1; c <= 15; c++) begin
      CMD_READY = (c == 3);
      tick();
      n_checks++;
      if ({ACK_OUT, BUSY} !== {4'b0, 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL to_early: cycle %0d got ack=%b busy=%b expected 0000 1", c, ACK_OUT, BUSY);
      end
    end
    CMD_READY = 1'b0;
    tick();
    n_checks++;
    if ({ACK_OUT, TIMEOUT_ERR, CMD_VALID} !== {4'b0001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL to_fire: got ack=%b err=%b v=%b expected 0001 1 0", ACK_OUT, TIMEOUT_ERR, CMD_VALID);
    end
    tick();
    n_checks++;
    if ({TIMEOUT_ERR, BUSY} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL to_sticky: got err=%b busy=%b expected 1 0", TIMEOUT_ERR, BUSY);
    end
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL to_clear: got err=%b expected 0", TIMEOUT_ERR);
    end
    pending = 4'b0010;
    wait_valid(10);
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_checks++;
      if (CMD_VALID !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL to_offer_hold: cycle %0d got v=%b expected 1", c, CMD_VALID);
      end
    end
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_checks++;
    if ({ACK_OUT, TIMEOUT_ERR, CMD_VALID} !== {4'b0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL to_set_wins: got ack=%b err=%b v=%b expected 0010 1 0", ACK_OUT, TIMEOUT_ERR, CMD_VALID);
    end
    tick();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL to_set_wins_hold: got err=%b expected 1", TIMEOUT_ERR);
    end
  endtask
`else
  task automatic test_no_timeout();
    pending = 4'b0001; CMD_READY = 1'b1;
    wait_valid(10);
    tick();
    CMD_READY = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ERR_CLR = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({ACK_OUT, BUSY, TIMEOUT_ERR} !== {4'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL nto_wait: cycle %0d got ack=%b busy=%b err=%b expected 0000 1 0", i, ACK_OUT, BUSY, TIMEOUT_ERR);
      end
    end
    ERR_CLR = 1'b0; CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    n_checks++;
    if (ACK_OUT !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL nto_ack: got %b expected 0001", ACK_OUT);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_ready_stall();
    test_spurious_done();
    test_reset_in_exec();
    test_random();
`ifdef ONESHOT_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got no completion expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
